// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared owner encoding and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int         STARVE_MAX_DEFAULT = 4;
    localparam int         WORD_OFF_W         = 2;
    localparam logic [1:0] WORD_OFF_ZERO      = 2'b00;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and RAM-side signals of the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    logic          if_req_valid;
    logic          if_req_ready;
    logic [AW-1:0] if_req_addr;
    logic          if_flush;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_data;
    logic          if_rsp_err;

    logic          d_req_valid;
    logic          d_req_ready;
    logic [AW-1:0] d_req_addr;
    logic          d_req_we;
    logic [3:0]    d_req_be;
    logic [31:0]   d_req_wdata;
    logic          d_rsp_valid;
    logic [31:0]   d_rsp_data;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  d_req_valid, d_req_addr, d_req_we, d_req_be, d_req_wdata,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output d_req_valid, d_req_addr, d_req_we, d_req_be, d_req_wdata,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// ============================================================================
// Module      : mem_arb_starve_ctr
// Description : Counts consecutive cycles a pending fetch loses to data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_if_valid,
    input  wire logic i_if_grant,
    input  wire logic i_d_grant,
    output logic      o_starved
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] c_max = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (!i_if_valid || i_if_grant) begin
            w_cnt_next = '0;
        end else if (i_d_grant && (r_cnt != c_max)) begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_starved = (r_cnt == c_max);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port RAM between a fetch and a data port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int AW         = 32
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    mem_port_arbiter_if.slave  bus
);
    owner_t r_owner, w_owner_next;
    logic   r_err, w_err_next;
    logic   r_store, w_store_next;
    logic   r_if_flush, w_if_flush_next;

    logic w_starved;
    logic w_grant_if;
    logic w_grant_d;
    logic w_if_misal;
    logic w_if_rsp_valid;
    logic w_d_rsp_valid;
    logic w_unused_addr_bits;

    assign w_unused_addr_bits = &{1'b0, bus.d_req_addr[WORD_OFF_W-1:0]};

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_if_valid (bus.if_req_valid),
        .i_if_grant (w_grant_if),
        .i_d_grant  (w_grant_d),
        .o_starved  (w_starved)
    );

    // Data wins by default; a fetch that has lost STARVE_MAX times in a row wins.
    assign w_grant_if = reset_n && bus.if_req_valid && (!bus.d_req_valid || w_starved);
    assign w_grant_d  = reset_n && bus.d_req_valid && !w_grant_if;
    assign w_if_misal = (bus.if_req_addr[WORD_OFF_W-1:0] != WORD_OFF_ZERO);

    assign bus.if_req_ready = w_grant_if;
    assign bus.d_req_ready  = w_grant_d;

    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_we      = 4'b0000;
        bus.mem_addr    = '0;
        bus.mem_wdata   = 32'h0;
        w_owner_next    = OWN_NONE;
        w_err_next      = 1'b0;
        w_store_next    = 1'b0;
        w_if_flush_next = 1'b0;
        if (w_grant_if) begin
            w_owner_next    = OWN_IF;
            w_err_next      = w_if_misal;
            w_if_flush_next = bus.if_flush;
            if (!w_if_misal) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = {bus.if_req_addr[AW-1:WORD_OFF_W], WORD_OFF_ZERO};
            end
        end else if (w_grant_d) begin
            w_owner_next  = OWN_D;
            w_store_next  = bus.d_req_we;
            bus.mem_en    = 1'b1;
            bus.mem_addr  = {bus.d_req_addr[AW-1:WORD_OFF_W], WORD_OFF_ZERO};
            bus.mem_we    = bus.d_req_we ? bus.d_req_be : 4'b0000;
            bus.mem_wdata = bus.d_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner    <= OWN_NONE;
            r_err      <= 1'b0;
            r_store    <= 1'b0;
            r_if_flush <= 1'b0;
        end else begin
            r_owner    <= w_owner_next;
            r_err      <= w_err_next;
            r_store    <= w_store_next;
            r_if_flush <= w_if_flush_next;
        end
    end

    // A flush seen at accept or during the response cycle kills the fetch response.
    assign w_if_rsp_valid = reset_n && (r_owner == OWN_IF) && !r_if_flush && !bus.if_flush;
    assign w_d_rsp_valid  = reset_n && (r_owner == OWN_D);

    assign bus.if_rsp_valid = w_if_rsp_valid;
    assign bus.if_rsp_err   = w_if_rsp_valid && r_err;
    assign bus.if_rsp_data  = (w_if_rsp_valid && !r_err) ? bus.mem_rdata : 32'h0;
    assign bus.d_rsp_valid  = w_d_rsp_valid;
    assign bus.d_rsp_data   = (w_d_rsp_valid && !r_store) ? bus.mem_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32)) bus ();

    mem_port_arbiter #(
        .STARVE_MAX (4),
        .AW         (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = 32'h0;
        bus.if_flush     = 1'b0;
        bus.d_req_valid  = 1'b0;
        bus.d_req_addr   = 32'h0;
        bus.d_req_we     = 1'b0;
        bus.d_req_be     = 4'b0000;
        bus.d_req_wdata  = 32'h0;
        bus.mem_rdata    = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".if_ready"}, 64'(bus.if_req_ready), 64'd0);
        chk({tag, ".d_ready"},  64'(bus.d_req_ready),  64'd0);
        chk({tag, ".mem_en"},   64'(bus.mem_en),       64'd0);
        chk({tag, ".mem_we"},   64'(bus.mem_we),       64'd0);
        chk({tag, ".if_rsp"},   64'({bus.if_rsp_valid, bus.if_rsp_err}), 64'd0);
        chk({tag, ".if_data"},  64'(bus.if_rsp_data),  64'd0);
        chk({tag, ".d_rsp"},    64'(bus.d_rsp_valid),  64'd0);
        chk({tag, ".d_data"},   64'(bus.d_rsp_data),   64'd0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;

        // Reset holds every output low even with requests present.
        step();
        bus.if_req_valid = 1'b1;
        bus.d_req_valid  = 1'b1;
        bus.mem_rdata    = 32'hFFFF_FFFF;
        smp();
        chk_all_zero("reset");
        step();
        reset_n = 1'b1;
        idle_inputs();

        // Aligned fetch 0x80
        step();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h80;
        smp();
        chk("fetch.if_ready", 64'(bus.if_req_ready), 64'd1);
        chk("fetch.d_ready",  64'(bus.d_req_ready),  64'd0);
        chk("fetch.mem_en",   64'(bus.mem_en),       64'd1);
        chk("fetch.mem_addr", 64'(bus.mem_addr),     64'h80);
        chk("fetch.mem_we",   64'(bus.mem_we),       64'd0);
        step();
        idle_inputs();
        bus.mem_rdata = 32'h0000_0013;
        smp();
        chk("fetch.rsp_valid", 64'(bus.if_rsp_valid), 64'd1);
        chk("fetch.rsp_data",  64'(bus.if_rsp_data),  64'h13);
        chk("fetch.rsp_err",   64'(bus.if_rsp_err),   64'd0);
        chk("fetch.d_data",    64'(bus.d_rsp_data),   64'd0);
        chk("fetch.d_rsp",     64'(bus.d_rsp_valid),  64'd0);

        // Starvation: four data grants, fetch on the fifth, then data again.
        for (int k = 0; k < 6; k++) begin
            step();
            bus.if_req_valid = 1'b1;
            bus.if_req_addr  = 32'h40;
            bus.d_req_valid  = 1'b1;
            bus.d_req_addr   = 32'h200;
            bus.d_req_we     = 1'b0;
            bus.mem_rdata    = 32'h1000 + 32'(k);
            smp();
            chk($sformatf("starve%0d.if_ready", k), 64'(bus.if_req_ready), 64'(k == 4));
            chk($sformatf("starve%0d.d_ready", k),  64'(bus.d_req_ready),  64'(k != 4));
            chk($sformatf("starve%0d.d_rsp", k),    64'(bus.d_rsp_valid),  64'(k >= 1 && k <= 4));
            chk($sformatf("starve%0d.if_rsp", k),   64'(bus.if_rsp_valid), 64'(k == 5));
            if (k == 2) chk("starve.d_data", 64'(bus.d_rsp_data), 64'h1002);
            if (k == 5) chk("starve.if_data", 64'(bus.if_rsp_data), 64'h1005);
        end
        step();
        idle_inputs();

        // Store to 0x103, top byte
        step();
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h103;
        bus.d_req_we    = 1'b1;
        bus.d_req_be    = 4'b1000;
        bus.d_req_wdata = 32'hAB00_0000;
        smp();
        chk("store.d_ready",   64'(bus.d_req_ready), 64'd1);
        chk("store.mem_en",    64'(bus.mem_en),      64'd1);
        chk("store.mem_addr",  64'(bus.mem_addr),    64'h100);
        chk("store.mem_we",    64'(bus.mem_we),      64'h8);
        chk("store.mem_wdata", 64'(bus.mem_wdata),   64'hAB00_0000);
        step();
        idle_inputs();
        bus.mem_rdata = 32'hDEAD_BEEF;
        smp();
        chk("store.rsp_valid", 64'(bus.d_rsp_valid), 64'd1);
        chk("store.rsp_data",  64'(bus.d_rsp_data),  64'd0);

        // Misaligned fetch 0x82
        step();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h82;
        smp();
        chk("misal.if_ready", 64'(bus.if_req_ready), 64'd1);
        chk("misal.mem_en",   64'(bus.mem_en),       64'd0);
        step();
        idle_inputs();
        bus.mem_rdata = 32'hFFFF_FFFF;
        smp();
        chk("misal.rsp", 64'({bus.if_rsp_valid, bus.if_rsp_err}), 64'h3);
        chk("misal.rsp_data", 64'(bus.if_rsp_data), 64'd0);

        // Flush in response cycle while a load is accepted back-to-back.
        step();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h84;
        step();
        idle_inputs();
        bus.if_flush    = 1'b1;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h300;
        bus.mem_rdata   = 32'h5A5A_5A5A;
        smp();
        chk("flush.if_rsp",   64'(bus.if_rsp_valid), 64'd0);
        chk("flush.if_data",  64'(bus.if_rsp_data),  64'd0);
        chk("flush.d_ready",  64'(bus.d_req_ready),  64'd1);
        step();
        idle_inputs();
        bus.if_flush  = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        smp();
        chk("flush.d_rsp",  64'(bus.d_rsp_valid), 64'd1);
        chk("flush.d_data", 64'(bus.d_rsp_data),  64'h1234_5678);

        // Flush raised in the accept cycle of a fetch
        step();
        idle_inputs();
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h88;
        bus.if_flush     = 1'b1;
        step();
        idle_inputs();
        bus.mem_rdata = 32'h7777_7777;
        smp();
        chk("flush_acc.if_rsp", 64'(bus.if_rsp_valid), 64'd0);

        // Reset in the response cycle of a load drops it.
        step();
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 32'h400;
        step();
        idle_inputs();
        reset_n       = 1'b0;
        bus.mem_rdata = 32'hCAFE_F00D;
        smp();
        chk("rst_pend.d_rsp", 64'(bus.d_rsp_valid), 64'd0);
        step();
        reset_n       = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        smp();
        chk_all_zero("post_rst");

        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
